// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the RV32 immediate encoder.
// Holds the opcode constants used by the core decoder and extractor, the
// immediate-format enum, and a helper that maps an opcode to its format.
package imm_encoder_pkg;

  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_BAD
  } imm_fmt_t;

  // Loads share the I-type immediate layout.
  function automatic imm_fmt_t fmt_of(input logic [6:0] opcode);
    imm_fmt_t fmt;
    case (opcode)
      OP_I, OP_L: fmt = FMT_I;
      OP_S:       fmt = FMT_S;
      OP_B:       fmt = FMT_B;
      OP_J:       fmt = FMT_J;
      default:    fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters an immediate and register fields into a
// 32-bit RV32 instruction word for the given format, and flags immediates
// that the format cannot represent.
// Ports:
//   fmt       in   immediate format (FMT_BAD always flags an error)
//   opcode    in   7-bit opcode, copied to inst[6:0]
//   rd/rs1/rs2 in  register fields (unused fields ignored per format)
//   funct3    in   funct3 field
//   imm       in   immediate in extractor units (B/J not shifted)
//   inst      out  encoded instruction word
//   range_err out  immediate out of range or unsupported format
module imm_pack
  import imm_encoder_pkg::*;
(
  input  imm_fmt_t    fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        range_err
);

  // A 12-bit signed field fits when bits 31..11 are all copies of the sign;
  // the J field is 20 bits wide, so bits 31..19 must match.
  logic narrow_ok;
  logic wide_ok;

  assign narrow_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign wide_ok   = (&imm[31:19]) | ~(|imm[31:19]);

  always_comb begin
    inst      = '0;
    range_err = 1'b0;
    case (fmt)
      FMT_I: begin
        inst      = {imm[11:0], rs1, funct3, rd, opcode};
        range_err = !narrow_ok;
      end
      FMT_S: begin
        inst      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_err = !narrow_ok;
      end
      FMT_B: begin
        // imm[11] is the sign; imm[10] lands in bit 7 as in the base ISA.
        inst      = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
        range_err = !narrow_ok;
      end
      FMT_J: begin
        inst      = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
        range_err = !wide_ok;
      end
      default: begin
        inst      = '0;
        range_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder feeding instruction memory.
// S1 captures a request and packs it (with range check); S2 holds the
// encoded word and its byte address until the sink accepts it.
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync flush)
//   in_valid_i / in_ready_o            request handshake
//   opcode_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i   request fields
//   out_valid_o / out_ready_i          output handshake
//   inst_o, addr_o                     encoded word and its byte address
//   err_o                              one-cycle pulse per dropped request
//   err_cnt_o                          saturating dropped-request count
//   busy_o                             either stage holds an entry
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int unsigned   CW        = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [6:0]    opcode_i,
  input  logic [4:0]    rd_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic [2:0]    funct3_i,
  input  logic [31:0]   imm_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [31:0]   inst_o,
  output logic [AW-1:0] addr_o,
  output logic          err_o,
  output logic [CW-1:0] err_cnt_o,
  output logic          busy_o
);

  // S1 state: raw request fields, decoded format
  logic        s1_v;
  imm_fmt_t    s1_fmt;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [31:0] s1_imm;

  logic [31:0] s1_inst;
  logic        s1_err;

  // S2 state
  logic        s2_v;

  logic out_fire;
  logic s1_adv;
  logic in_fire;

  imm_pack u_pack (
    .fmt       (s1_fmt),
    .opcode    (s1_opcode),
    .rd        (s1_rd),
    .rs1       (s1_rs1),
    .rs2       (s1_rs2),
    .funct3    (s1_funct3),
    .imm       (s1_imm),
    .inst      (s1_inst),
    .range_err (s1_err)
  );

  assign out_fire = s2_v && out_ready_i;
  // Error entries use the same advance rule so ordering of err_o pulses
  // matches request order relative to emitted words.
  assign s1_adv   = s1_v && (!s2_v || out_fire);
  // rst_i is included so the port reads 0 for the whole reset, not just
  // after the registers have cleared.
  assign in_ready_o = !rst_i && !clear_i && (!s1_v || s1_adv);
  assign in_fire    = in_valid_i && in_ready_o;

  assign err_o       = !clear_i && s1_adv && s1_err;
  assign out_valid_o = s2_v;
  assign busy_o      = s1_v | s2_v;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v      <= 1'b0;
      s1_fmt    <= FMT_BAD;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_imm    <= '0;
      s2_v      <= 1'b0;
      inst_o    <= '0;
      addr_o    <= BASE_ADDR;
      err_cnt_o <= '0;
    end else if (clear_i) begin
      // Flush wins over every handshake in the same cycle.
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      inst_o    <= '0;
      addr_o    <= BASE_ADDR;
      err_cnt_o <= '0;
    end else begin
      if (in_fire) begin
        s1_v      <= 1'b1;
        s1_fmt    <= fmt_of(opcode_i);
        s1_opcode <= opcode_i;
        s1_rd     <= rd_i;
        s1_rs1    <= rs1_i;
        s1_rs2    <= rs2_i;
        s1_funct3 <= funct3_i;
        s1_imm    <= imm_i;
      end else if (s1_adv) begin
        s1_v <= 1'b0;
      end

      // S2 only changes when empty or draining, so inst_o is stable under stall.
      if (s1_adv && !s1_err) begin
        s2_v   <= 1'b1;
        inst_o <= s1_inst;
      end else if (out_fire) begin
        s2_v <= 1'b0;
      end

      if (out_fire) begin
        addr_o <= addr_o + AW'(4);
      end

      if (err_o && (err_cnt_o != {CW{1'b1}})) begin
        err_cnt_o <= err_cnt_o + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  localparam logic [6:0] T_OP_I   = 7'b0010011;
  localparam logic [6:0] T_OP_L   = 7'b0000011;
  localparam logic [6:0] T_OP_S   = 7'b0100011;
  localparam logic [6:0] T_OP_B   = 7'b1100011;
  localparam logic [6:0] T_OP_J   = 7'b1101111;
  localparam logic [6:0] T_OP_BAD = 7'b0110011;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] addr;
  logic        err;
  logic [7:0]  err_cnt;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int err_pulses = 0;
  req_t  req_q[$];
  word_t out_q[$];

  always #5 clk = ~clk;

  imm_encoder #(.AW(32), .BASE_ADDR(32'h0), .CW(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .opcode_i    (opcode),
    .rd_i        (rd),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .funct3_i    (funct3),
    .imm_i       (imm),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .inst_o      (inst),
    .addr_o      (addr),
    .err_o       (err),
    .err_cnt_o   (err_cnt),
    .busy_o      (busy)
  );

  // Records every output handshake that will take effect at the next edge.
  always @(negedge clk) begin
    if (!rst && !clear && out_valid && out_ready) begin
      word_t w;
      w.inst = inst;
      w.addr = addr;
      out_q.push_back(w);
      $display("txn out inst=%08h addr=%08h", inst, addr);
    end
    if (!rst && err) err_pulses++;
  end

  // Reference encoder: places immediate bits with shifts and masks.
  function automatic logic [31:0] ref_encode(input req_t r, output bit bad);
    int unsigned u;
    int s;
    int unsigned w;
    u = r.imm;
    s = $signed(r.imm);
    w = 0;
    bad = 1'b0;
    if (r.op == T_OP_I || r.op == T_OP_L) begin
      bad = !(s >= -2048 && s <= 2047);
      w = ((u & 32'hFFF) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (32'(r.rd) << 7);
    end else if (r.op == T_OP_S) begin
      bad = !(s >= -2048 && s <= 2047);
      w = (((u >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15)
        | (32'(r.f3) << 12) | ((u & 32'h1F) << 7);
    end else if (r.op == T_OP_B) begin
      bad = !(s >= -2048 && s <= 2047);
      w = (((u >> 11) & 1) << 31) | (((u >> 4) & 32'h3F) << 25) | (32'(r.rs2) << 20)
        | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | ((u & 32'hF) << 8) | (((u >> 10) & 1) << 7);
    end else if (r.op == T_OP_J) begin
      bad = !(s >= -524288 && s <= 524287);
      w = (((u >> 19) & 1) << 31) | ((u & 32'h3FF) << 21) | (((u >> 10) & 1) << 20)
        | (((u >> 11) & 32'hFF) << 12) | (32'(r.rd) << 7);
    end else begin
      bad = 1'b1;
    end
    return w | 32'(r.op);
  endfunction

  // Core-style extractor: recovers the sign-extended immediate from a word.
  function automatic logic [31:0] ref_extract(input logic [31:0] word);
    int unsigned w;
    int v;
    w = word;
    v = 0;
    case (word[6:0])
      T_OP_I, T_OP_L: v = $signed(word) >>> 20;
      T_OP_S: begin
        v = int'(((w >> 25) << 5) | ((w >> 7) & 32'h1F));
        if (v >= 2048) v -= 4096;
      end
      T_OP_B: begin
        v = int'((((w >> 31) & 1) << 11) | (((w >> 7) & 1) << 10)
          | (((w >> 25) & 32'h3F) << 4) | ((w >> 8) & 32'hF));
        if (v >= 2048) v -= 4096;
      end
      T_OP_J: begin
        v = int'((((w >> 31) & 1) << 19) | (((w >> 12) & 32'hFF) << 11)
          | (((w >> 20) & 1) << 10) | ((w >> 21) & 32'h3FF));
        if (v >= 524288) v -= 1048576;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic req_t mk(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f, input logic [31:0] im);
    req_t r;
    r.op = op; r.rd = d; r.rs1 = s1; r.rs2 = s2; r.f3 = f; r.imm = im;
    return r;
  endfunction

  task automatic clear_pulse();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    out_q.delete();
    req_q.delete();
    err_pulses = 0;
  endtask

  // Offers req_q[first..last-1] in order with in_valid held; returns next unaccepted index.
  task automatic stream(input int first, input int last, input int max_cycles,
                        input bit rnd_ready, output int next);
    int idx;
    idx = first;
    for (int c = 0; c < max_cycles && idx < last; c++) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      opcode = req_q[idx].op; rd = req_q[idx].rd; rs1 = req_q[idx].rs1;
      rs2 = req_q[idx].rs2; funct3 = req_q[idx].f3; imm = req_q[idx].imm;
      @(negedge clk);
      if (in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    next = idx;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain_timeout: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    vectors++; if (inst !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %08h want 0", inst); end
    vectors++; if (addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %08h want 0", addr); end
    vectors++; if (err_cnt !== 8'h0) begin miscompares++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    vectors++; if (busy !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rst_busy_err: got %0b/%0b want 0/0", busy, err); end
    repeat (2) @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_i_type();
    int n;
    bit bad;
    clear_pulse();
    out_ready = 1'b1;
    req_q.push_back(mk(T_OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF));
    stream(0, 1, 10, 1'b0, n);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL i_latency_early: out_valid=%0b want 0", out_valid); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL i_latency: out_valid=%0b want 1", out_valid); end
    vectors++; if (inst !== 32'hFFF00093) begin miscompares++; $display("FAIL i_inst: got %08h want FFF00093", inst); end
    vectors++; if (inst !== ref_encode(req_q[0], bad)) begin miscompares++; $display("FAIL i_model: got %08h want %08h", inst, ref_encode(req_q[0], bad)); end
    vectors++; if (addr !== 32'h0) begin miscompares++; $display("FAIL i_addr: got %08h want 0", addr); end
    wait_idle(10);
  endtask

  task automatic test_s_b_type();
    int n;
    clear_pulse();
    out_ready = 1'b1;
    req_q.push_back(mk(T_OP_S, 5'd0, 5'd2, 5'd5, 3'b010, 32'h8));
    req_q.push_back(mk(T_OP_B, 5'd0, 5'd1, 5'd2, 3'b000, 32'hFFFF_FFFE));
    stream(0, 2, 10, 1'b0, n);
    wait_idle(20);
    vectors++;
    if (out_q.size() != 2) begin
      miscompares++; $display("FAIL sb_count: got %0d words want 2", out_q.size());
    end else begin
      vectors++; if (out_q[0].inst !== 32'h00512423) begin miscompares++; $display("FAIL s_inst: got %08h want 00512423", out_q[0].inst); end
      vectors++; if (ref_extract(out_q[0].inst) !== 32'h8) begin miscompares++; $display("FAIL s_roundtrip: got %08h want 00000008", ref_extract(out_q[0].inst)); end
      vectors++; if (out_q[1].inst !== 32'hFE208EE3) begin miscompares++; $display("FAIL b_inst: got %08h want FE208EE3", out_q[1].inst); end
      vectors++; if (out_q[1].addr !== 32'h4) begin miscompares++; $display("FAIL b_addr: got %08h want 4", out_q[1].addr); end
    end
  endtask

  task automatic test_range_error();
    int n;
    bit bad;
    clear_pulse();
    out_ready = 1'b1;
    req_q.push_back(mk(T_OP_I, 5'd3, 5'd1, 5'd0, 3'd0, 32'h800));
    req_q.push_back(mk(T_OP_I, 5'd7, 5'd4, 5'd0, 3'd0, 32'h5));
    stream(0, 2, 10, 1'b0, n);
    wait_idle(20);
    repeat (3) @(negedge clk);
    vectors++; if (err_pulses != 1) begin miscompares++; $display("FAIL err_pulse: got %0d pulses want 1", err_pulses); end
    vectors++; if (err_cnt !== 8'd1) begin miscompares++; $display("FAIL err_cnt: got %0d want 1", err_cnt); end
    vectors++;
    if (out_q.size() != 1) begin
      miscompares++; $display("FAIL err_words: got %0d words want 1", out_q.size());
    end else begin
      vectors++; if (out_q[0].addr !== 32'h0) begin miscompares++; $display("FAIL err_next_addr: got %08h want 0", out_q[0].addr); end
      vectors++; if (out_q[0].inst !== ref_encode(req_q[1], bad)) begin miscompares++; $display("FAIL err_next_inst: got %08h want %08h", out_q[0].inst, ref_encode(req_q[1], bad)); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit bad;
    clear_pulse();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      req_q.push_back(mk(T_OP_I, 5'(i + 1), 5'(i + 2), 5'd0, 3'(i), 32'(i * 3)));
    stream(0, 3, 6, 1'b0, n);
    @(negedge clk);
    vectors++; if (n != 2) begin miscompares++; $display("FAIL bp_accepts: got %0d want 2", n); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy: got %0b want 1", busy); end
    out_ready = 1'b1;
    stream(n, 3, 20, 1'b0, n);
    wait_idle(20);
    vectors++;
    if (out_q.size() != 3) begin
      miscompares++; $display("FAIL bp_count: got %0d words want 3", out_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (out_q[i].inst !== ref_encode(req_q[i], bad) || out_q[i].addr !== 32'(4 * i)) begin
          miscompares++;
          $display("FAIL bp_word%0d: got %08h@%08h want %08h@%08h", i, out_q[i].inst, out_q[i].addr,
                   ref_encode(req_q[i], bad), 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_random();
    int n;
    int exp_err;
    int k;
    bit bad;
    word_t exp_q[$];
    logic [31:0] a;
    clear_pulse();
    exp_err = 0;
    a = 32'h0;
    for (int i = 0; i < 60; i++) begin
      req_t r;
      int sel;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: r.op = T_OP_I;
        1: r.op = T_OP_L;
        2: r.op = T_OP_S;
        3: r.op = T_OP_B;
        4: r.op = T_OP_J;
        default: r.op = T_OP_BAD;
      endcase
      r.rd = 5'($urandom()); r.rs1 = 5'($urandom()); r.rs2 = 5'($urandom()); r.f3 = 3'($urandom());
      if ($urandom_range(0, 7) == 0) r.imm = $urandom();
      else if (r.op == T_OP_J) r.imm = 32'(int'($urandom_range(0, 1048575)) - 524288);
      else r.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      req_q.push_back(r);
      begin
        word_t w;
        w.inst = ref_encode(r, bad);
        w.addr = a;
        if (bad) exp_err++;
        else begin exp_q.push_back(w); a = a + 32'd4; end
      end
    end
    stream(0, 60, 2000, 1'b1, n);
    out_ready = 1'b1;
    wait_idle(50);
    vectors++; if (n != 60) begin miscompares++; $display("FAIL rnd_accepts: got %0d want 60", n); end
    vectors++; if (err_cnt !== 8'(exp_err)) begin miscompares++; $display("FAIL rnd_err_cnt: got %0d want %0d", err_cnt, exp_err); end
    vectors++;
    if (out_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rnd_count: got %0d words want %0d", out_q.size(), exp_q.size());
    end else begin
      k = 0;
      for (int i = 0; i < 60; i++) begin
        if (!(ref_encode(req_q[i], bad) == 32'h0 && 1'b0)) begin
          void'(ref_encode(req_q[i], bad));
          if (!bad) begin
            vectors++;
            if (out_q[k].inst !== exp_q[k].inst || out_q[k].addr !== exp_q[k].addr) begin
              miscompares++;
              $display("FAIL rnd_word%0d: got %08h@%08h want %08h@%08h", k, out_q[k].inst, out_q[k].addr,
                       exp_q[k].inst, exp_q[k].addr);
            end
            vectors++;
            if (ref_extract(out_q[k].inst) !== req_q[i].imm) begin
              miscompares++;
              $display("FAIL rnd_roundtrip%0d: got %08h want %08h", k, ref_extract(out_q[k].inst), req_q[i].imm);
            end
            k++;
          end
        end
      end
    end
  endtask

  task automatic test_flush();
    int n;
    clear_pulse();
    out_ready = 1'b1;
    req_q.push_back(mk(T_OP_J, 5'd9, 5'd0, 5'd0, 3'd0, 32'h12345));
    req_q.push_back(mk(T_OP_I, 5'd2, 5'd3, 5'd0, 3'd1, 32'h10));
    req_q.push_back(mk(T_OP_S, 5'd0, 5'd3, 5'd4, 3'd2, 32'h20));
    req_q.push_back(mk(T_OP_I, 5'd5, 5'd6, 5'd0, 3'd0, 32'h7));
    stream(0, 1, 10, 1'b0, n);
    wait_idle(20);
    vectors++; if (addr !== 32'h4) begin miscompares++; $display("FAIL fl_pre_addr: got %08h want 4", addr); end
    out_ready = 1'b0;
    stream(1, 3, 6, 1'b0, n);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL fl_full: valid/busy=%0b/%0b want 1/1", out_valid, busy); end
    @(posedge clk); #1;
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    opcode = req_q[3].op; rd = req_q[3].rd; rs1 = req_q[3].rs1; imm = req_q[3].imm;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fl_in_ready: got %0b want 0", in_ready); end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fl_busy: got %0b want 0", busy); end
    vectors++; if (addr !== 32'h0) begin miscompares++; $display("FAIL fl_addr: got %08h want 0", addr); end
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0 || out_q.size() != 1) begin miscompares++; $display("FAIL fl_not_taken: busy=%0b words=%0d want 0/1", busy, out_q.size()); end
  endtask

  task automatic test_async_reset();
    int n;
    bit bad;
    clear_pulse();
    out_ready = 1'b0;
    req_q.push_back(mk(T_OP_BAD, 5'd1, 5'd1, 5'd1, 3'd0, 32'h0));
    req_q.push_back(mk(T_OP_I, 5'd1, 5'd2, 5'd0, 3'd0, 32'h1));
    req_q.push_back(mk(T_OP_I, 5'd3, 5'd4, 5'd0, 3'd0, 32'h2));
    req_q.push_back(mk(T_OP_L, 5'd8, 5'd9, 5'd0, 3'd2, 32'hFFFF_F800));
    stream(0, 3, 8, 1'b0, n);
    @(negedge clk);
    vectors++; if (err_cnt !== 8'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL ar_pre: err_cnt/busy=%0d/%0b want 1/1", err_cnt, busy); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL ar_valid: valid/busy=%0b/%0b want 0/0", out_valid, busy); end
    vectors++; if (inst !== 32'h0 || addr !== 32'h0) begin miscompares++; $display("FAIL ar_inst_addr: got %08h/%08h want 0/0", inst, addr); end
    vectors++; if (err_cnt !== 8'h0 || in_ready !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL ar_cnt_ready: cnt/ready/err=%0d/%0b/%0b want 0/0/0", err_cnt, in_ready, err); end
    out_ready = 1'b1;
    #2;
    rst = 1'b0;
    out_q.delete();
    stream(3, 4, 10, 1'b0, n);
    wait_idle(20);
    vectors++;
    if (out_q.size() != 1) begin
      miscompares++; $display("FAIL ar_resume_count: got %0d words want 1", out_q.size());
    end else begin
      vectors++;
      if (out_q[0].inst !== ref_encode(req_q[3], bad) || out_q[0].addr !== 32'h0) begin
        miscompares++;
        $display("FAIL ar_resume: got %08h@%08h want %08h@00000000", out_q[0].inst, out_q[0].addr, ref_encode(req_q[3], bad));
      end
    end
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_s_b_type();
    test_range_error();
    test_backpressure();
    test_random();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate extractor: packs register fields and an immediate into a 32-bit RV32 instruction word for the I, L, S, B and J formats.
- Sits between the test/boot loader and instruction memory, producing a stream of encoded words with write addresses.
- Two-stage pipeline with valid/ready on both sides, immediate range checking, and an error counter.

Parameters:
- AW, 32: width of addr_o.
- BASE_ADDR, 0: addr_o value after reset or clear.
- CW, 8: width of err_cnt_o (saturating).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- clear_i  in  1  synchronous flush: empties pipeline, restores addr_o and err_cnt_o
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i&&in_ready_o
- opcode_i  in  7  0010011 I, 0000011 L, 0100011 S, 1100011 B, 1101111 J
- rd_i  in  5  destination register
- rs1_i  in  5  source register 1
- rs2_i  in  5  source register 2
- funct3_i  in  3  funct3 field
- imm_i  in  32  immediate, in the same units the core's extractor returns (B and J not shifted)
- out_valid_o  out  1  encoded word valid
- out_ready_i  in  1  sink ready
- inst_o  out  32  encoded instruction
- addr_o  out  AW  byte address for inst_o
- err_o  out  1  one-cycle pulse when a request is dropped
- err_cnt_o  out  CW  dropped-request count
- busy_o  out  1  either stage holds an entry

Behaviour:
Reset values:
- rst_i asserted: both stage valids=0, out_valid_o=0, inst_o=0, addr_o=BASE_ADDR, err_o=0, err_cnt_o=0, in_ready_o=0 while rst_i is high.
- Reset mid-transfer discards all entries.

Stage S1 (capture):
- Loads on input handshake.
- in_ready_o = !clear_i && (!s1_v || s1 advances this cycle).

Range check (in S1):
- I/L/S/B: imm_i[31:11] all equal.
- J: imm_i[31:19] all equal.
- Any other opcode: error.

Encoding (opcode always in [6:0]):
- I/L: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=f3, [11:7]=rd.
- S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=f3, [11:7]=imm[4:0].
- B: [31]=imm[11], [30:25]=imm[9:4], [24:20]=rs2, [19:15]=rs1, [14:12]=f3, [11:8]=imm[3:0], [7]=imm[10].
- J: [31]=imm[19], [30:21]=imm[9:0], [20]=imm[10], [19:12]=imm[18:11], [11:7]=rd.
- Fields a format does not use are ignored.
- Round-trip invariant: the core extractor applied to inst_o returns imm_i.

S1 -> S2 transfer:
- S1 advances when s2 is empty or the output handshake occurs this cycle.
- Error entries: not loaded into S2. err_o=1 for that cycle; err_cnt_o+1, saturating at 2^CW-1.

S2 (output):
- S2 drives out_valid_o and inst_o.
- inst_o, out_valid_o and addr_o are held stable while out_valid_o && !out_ready_i.
- On output handshake: addr_o += 4, wrapping modulo 2^AW.

Timing and throughput:
- Latency is 2 cycles from accept to out_valid_o with no backpressure.
- Throughput is 1 word/cycle.
- Under a stall, both stages fill and then in_ready_o=0.

Other rules:
- busy_o = s1_v | s2_v.
- clear_i has priority over all handshakes: an input offered in the same cycle is not accepted, an output handshake in that cycle does not advance addr_o, and err_o is 0.

Decomposition:
- Shared package holds the opcode constants (OP_I, OP_L, OP_S, OP_B, OP_J), matching those used by the core decoder/extractor, plus an imm_fmt_t enum {FMT_I, FMT_S, FMT_B, FMT_J, FMT_BAD}.
- One combinational sub-module, imm_pack: inputs fmt, fields and imm; outputs inst and range_err. Instantiated in S1.
- The pipeline, counters and handshake logic stay in imm_encoder.

Test Plan:
- I-type: opcode 0010011, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF -> inst_o=0xFFF00093, addr_o=0, out_valid_o 2 cycles after accept.
- S-type: opcode 0100011, rs1=2, rs2=5, f3=010, imm=8 -> inst_o=0x00512423. Feeding inst_o through the core extractor returns 0x00000008.
- B-type: opcode 1100011, rs1=1, rs2=2, f3=0, imm=0xFFFFFFFE -> inst_o=0xFE208EE3. Randomised round-trip check over all five formats.
- Range error: I-type imm=0x800, then a valid request -> err_o single pulse, err_cnt_o=1, no word emitted for the bad request, next word at addr_o=0.
- Backpressure: out_ready_i=0, offer 3 requests -> in_ready_o low after 2 accepts. Raise out_ready_i -> 3 words in order at addr_o 0, 4, 8.
- Flush and reset: clear_i with both stages full and in_valid_i=1 -> next cycle busy_o=0, addr_o=BASE_ADDR, request not taken. Assert rst_i asynchronously mid-stream -> outputs reach reset values immediately without a clock edge.
